red_pitaya_adc_decim: RTL
=========================

# red_pitaya_adc_decim

Two-channel decimator that sits directly downstream of the analog front-end. It consumes the 14-bit two's-complement ADC samples, one per `adc_clk` cycle, and produces a reduced-rate stream for the scope and acquisition logic. Each output sample is either the boxcar average or a plain subsample of a power-of-two window of input samples. The window size is selectable at run time, and a single-cycle valid strobe marks each output.

## Interface
Parameters:
- `ADW`, 14, ADC sample width (two's complement)
- `CW`, 17, window counter width (covers the largest window, 65536)

Ports:
- `adc_clk_i`  in  1  ADC clock; the sole clock
- `adc_rstn_i`  in  1  reset; asynchronous, active-low
- `adc_dat_a_i`  in  ADW  CHA sample, new every cycle
- `adc_dat_b_i`  in  ADW  CHB sample, new every cycle
- `dec_sel_i`  in  3  window select: 0→1, 1→8, 2→64, 3→1024, 4→8192, 5→65536; 6 and 7 behave as 0
- `dec_clr_i`  in  1  synchronous restart of the current window
- `dat_a_o`  out  ADW  CHA decimated sample
- `dat_b_o`  out  ADW  CHB decimated sample
- `dat_v_o`  out  1  one-cycle strobe; both `dat_*_o` are valid in this cycle

## Operation
- State (shared by both channels):
  - `sel_r`, the registered select
  - `cnt`, a CW-bit counter
  - one accumulator per channel, ADW+CW = 31 bits signed
- Window size N and shift S come from `sel_r`: (1,0), (8,3), (64,6), (1024,10), (8192,13), (65536,16).
- Normal cycle, with neither restart condition active:
  - the sample is accepted;
  - if `cnt` < N−1: `acc` += sign-extended sample and `cnt` += 1;
  - if `cnt` == N−1: the output register loads (`acc` + sample) >>> S (arithmetic shift, truncation toward −inf), `acc` ← 0, `cnt` ← 0, and `dat_v_o` ← 1 on the next edge.
- Restart condition: `dec_sel_i` ≠ `sel_r`, or `dec_clr_i` = 1. In that cycle:
  - `sel_r` ← `dec_sel_i`; `cnt` ← 0; both accumulators ← 0;
  - the current sample is discarded;
  - `dat_v_o` is 0 on the next edge, even if `cnt` was N−1;
  - `dat_*_o` hold their previous values;
  - the next accepted sample is the first sample of the new window.
- N = 1: every accepted sample is output unchanged, one cycle later; `dat_v_o` stays high continuously.
- No saturation is needed: for ADW = 14 and N ≤ 2^16, the sum of N samples fits in 31 bits and the shifted result fits in ADW bits.
- `dat_*_o` hold their value between strobes.

## Timing
- Reset (asynchronous assert; release on the next `adc_clk_i` edge): `dat_a_o` = 0, `dat_b_o` = 0, `dat_v_o` = 0, `sel_r` = 0, `cnt` = 0, accumulators = 0.
- First window after reset:
  - it starts on the first edge after release;
  - if `dec_sel_i` ≠ 0 at that point, the first cycle is a restart cycle.
- Latency: output registered 1 cycle after the last sample of the window is presented.
- Strobe period: steady-state spacing of `dat_v_o` is exactly N cycles.
- The output is a single register stage. An optional internal pipeline register before the final add is allowed only if total latency stays at 1 cycle from the last sample.
- Reset asserted mid-window: all state clears immediately and no strobe is emitted.

## Configuration
- `ADC_DECIM_AVG_EN` defined:
  - boxcar averaging as described above.
- `ADC_DECIM_AVG_EN` not defined:
  - accumulators are not built;
  - at `cnt` == N−1 the output register loads the current raw sample (plain subsample, the last sample of each window);
  - counter, strobe, restart and reset behaviour are identical to the averaging build.

## Structure
- Shared package `red_pitaya_adc_pkg`:
  - window-size and shift tables indexed by `dec_sel_i`;
  - ADW default.
- Sub-module `red_pitaya_decim_ch`:
  - one channel's accumulator and output register;
  - instantiated twice.
- The top block owns `sel_r`, `cnt`, restart detection and `dat_v_o`.

## Test plan
- Select 0, ramp input −5, −4, … → `dat_a_o` equals the input delayed 1 cycle; `dat_v_o` high every cycle after reset release.
- Select 1, CHA constant 100, CHB constant −8191 → strobe every 8 cycles with `dat_a_o` = 100 and `dat_b_o` = −8191; without `ADC_DECIM_AVG_EN`, the same values.
- Select 1, CHA sequence 0, 1, …, 7 repeating:
  - with `ADC_DECIM_AVG_EN`: `dat_a_o` = 3 (28 >>> 3);
  - without `ADC_DECIM_AVG_EN`: `dat_a_o` = 7.
- Select 5, CHA constant +8191 → first strobe 65536 cycles after the window starts, `dat_a_o` = 8191; no overflow.
- Change `dec_sel_i` from 2 to 1 at `cnt` = 40 → no strobe for the partial window; the next strobe comes 1 + 8 cycles later. Repeat with a `dec_clr_i` pulse in place of the select change; timing is identical.
- Assert `adc_rstn_i` low mid-window, asynchronously (between edges) → all outputs 0 immediately; after release, the first strobe comes exactly N cycles after the first post-release edge.

Source files
------------

// File: rtl/red_pitaya_adc_pkg.sv
// ----------------------------------------------------------------------------
// red_pitaya_adc_pkg
// Shared constants and lookup helpers for the two-channel ADC decimator.
//   ADC_ADW           : default ADC sample width (two's complement)
//   ADC_CW            : default window counter width (holds 65535)
//   dec_last(sel)     : last counter index of the window (N-1) for a select
//   dec_shift(sel)    : log2(N) for a select, used to scale the window sum
// Selects 6 and 7 fall through to the N = 1 entry.
// ----------------------------------------------------------------------------
package red_pitaya_adc_pkg;

    localparam int ADC_ADW = 14;
    localparam int ADC_CW  = 17;

    function automatic logic [ADC_CW-1:0] dec_last(input logic [2:0] sel);
        logic [ADC_CW-1:0] v;
        case (sel)
            3'd1:    v = 17'd7;
            3'd2:    v = 17'd63;
            3'd3:    v = 17'd1023;
            3'd4:    v = 17'd8191;
            3'd5:    v = 17'd65535;
            default: v = 17'd0;
        endcase
        return v;
    endfunction

    function automatic logic [4:0] dec_shift(input logic [2:0] sel);
        logic [4:0] v;
        case (sel)
            3'd1:    v = 5'd3;
            3'd2:    v = 5'd6;
            3'd3:    v = 5'd10;
            3'd4:    v = 5'd13;
            3'd5:    v = 5'd16;
            default: v = 5'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/red_pitaya_decim_ch.sv
// ----------------------------------------------------------------------------
// red_pitaya_decim_ch
// One decimator channel: optional window accumulator plus the output register.
// Window bookkeeping (counter, restart, strobe) lives in the parent.
// Build option: ADC_DECIM_AVG_EN selects boxcar averaging; without it the
// channel outputs the last raw sample of each window (plain subsample).
// Ports:
//   i_clk      : ADC clock
//   i_rstn     : asynchronous active-low reset
//   i_dat      : input sample, two's complement
//   i_restart  : discard this sample and start a new window
//   i_last     : this sample closes the current window
//   i_shift    : log2(window size) (averaging build only)
//   o_dat      : decimated sample, held between strobes
// ----------------------------------------------------------------------------
module red_pitaya_decim_ch
    import red_pitaya_adc_pkg::*;
#(
    parameter int ADW = ADC_ADW,
    parameter int CW  = ADC_CW
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic [ADW-1:0] i_dat,
    input  logic           i_restart,
    input  logic           i_last,
`ifdef ADC_DECIM_AVG_EN
    input  logic [4:0]     i_shift,
`endif
    output logic [ADW-1:0] o_dat
);

    logic [ADW-1:0] r_dat;

`ifdef ADC_DECIM_AVG_EN
    localparam int AW = ADW + CW;

    logic signed [AW-1:0]  r_acc;
    logic signed [AW-1:0]  w_sum;
    logic signed [ADW-1:0] w_avg;

    // Closing sample is folded in combinationally so the result is
    // registered one cycle after the last sample is presented.
    assign w_sum = r_acc + {{CW{i_dat[ADW-1]}}, i_dat};
    // Arithmetic shift floors toward -inf; the result always fits in ADW.
    assign w_avg = ADW'(w_sum >>> i_shift);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_acc <= '0;
            r_dat <= '0;
        end else if (i_restart) begin
            r_acc <= '0;
        end else if (i_last) begin
            r_acc <= '0;
            r_dat <= w_avg;
        end else begin
            r_acc <= w_sum;
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_dat <= '0;
        end else if (!i_restart && i_last) begin
            r_dat <= i_dat;
        end
    end
`endif

    assign o_dat = r_dat;

endmodule

// File: rtl/red_pitaya_adc_decim.sv
// ----------------------------------------------------------------------------
// red_pitaya_adc_decim
// Two-channel power-of-two decimator for the ADC front-end. Each output is
// the boxcar average (ADC_DECIM_AVG_EN defined) or the last raw sample
// (ADC_DECIM_AVG_EN undefined) of a window of N = 1/8/64/1024/8192/65536.
// Ports:
//   adc_clk_i    : ADC clock, sole clock
//   adc_rstn_i   : asynchronous active-low reset
//   adc_dat_a_i  : channel A sample, one per cycle
//   adc_dat_b_i  : channel B sample, one per cycle
//   dec_sel_i    : window select (0..5; 6 and 7 act as 0)
//   dec_clr_i    : restart the current window
//   dat_a_o      : channel A decimated sample
//   dat_b_o      : channel B decimated sample
//   dat_v_o      : output strobe
// Output protocol: valid-only, no backpressure. dat_v_o is high for exactly
// one cycle per completed window (continuously for N = 1); dat_a_o/dat_b_o
// are valid in that cycle and hold their value until the next strobe.
// ----------------------------------------------------------------------------
module red_pitaya_adc_decim
    import red_pitaya_adc_pkg::*;
#(
    parameter int ADW = ADC_ADW,
    parameter int CW  = ADC_CW
) (
    input  logic           adc_clk_i,
    input  logic           adc_rstn_i,
    input  logic [ADW-1:0] adc_dat_a_i,
    input  logic [ADW-1:0] adc_dat_b_i,
    input  logic [2:0]     dec_sel_i,
    input  logic           dec_clr_i,
    output logic [ADW-1:0] dat_a_o,
    output logic [ADW-1:0] dat_b_o,
    output logic           dat_v_o
);

    logic [2:0]    r_sel;
    logic [CW-1:0] r_cnt;
    logic          r_vld;

    logic          w_restart;
    logic          w_last;

    // Any select change restarts the window, even between selects that
    // share a window size (e.g. 0 -> 6).
    assign w_restart = (dec_sel_i != r_sel) || dec_clr_i;
    assign w_last    = (r_cnt == CW'(dec_last(r_sel)));

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_sel <= '0;
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else if (w_restart) begin
            r_sel <= dec_sel_i;
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else if (w_last) begin
            r_cnt <= '0;
            r_vld <= 1'b1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
            r_vld <= 1'b0;
        end
    end

`ifdef ADC_DECIM_AVG_EN
    logic [4:0] w_shift;
    assign w_shift = dec_shift(r_sel);
`endif

    red_pitaya_decim_ch #(
        .ADW (ADW),
        .CW  (CW)
    ) u_ch_a (
        .i_clk     (adc_clk_i),
        .i_rstn    (adc_rstn_i),
        .i_dat     (adc_dat_a_i),
        .i_restart (w_restart),
        .i_last    (w_last),
`ifdef ADC_DECIM_AVG_EN
        .i_shift   (w_shift),
`endif
        .o_dat     (dat_a_o)
    );

    red_pitaya_decim_ch #(
        .ADW (ADW),
        .CW  (CW)
    ) u_ch_b (
        .i_clk     (adc_clk_i),
        .i_rstn    (adc_rstn_i),
        .i_dat     (adc_dat_b_i),
        .i_restart (w_restart),
        .i_last    (w_last),
`ifdef ADC_DECIM_AVG_EN
        .i_shift   (w_shift),
`endif
        .o_dat     (dat_b_o)
    );

    assign dat_v_o = r_vld;

endmodule
